// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall control block.
package hazard_stall_unit_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // Control output values presented while Reset is asserted.
    localparam logic PCWRITE_RST    = 1'b1;
    localparam logic IFIDWRITE_RST  = 1'b1;
    localparam logic IFIDFLUSH_RST  = 1'b0;
    localparam logic IDEXBUBBLE_RST = 1'b0;
    localparam logic BUSY_RST       = 1'b0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage request inputs and pipeline control outputs of the stall unit.
interface hazard_stall_unit_if #(
    parameter int REG_ADDR_W = hazard_stall_unit_pkg::REG_ADDR_W,
    parameter int STAT_W     = 16
);
    logic                  ID_EX_MemRead;
    logic [REG_ADDR_W-1:0] ID_EX_Rt;
    logic [REG_ADDR_W-1:0] IF_ID_Rs;
    logic [REG_ADDR_W-1:0] IF_ID_Rt;
    logic                  IF_ID_UsesRt;
    logic                  BranchTaken;
    logic                  MulStart;
    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  IFIDFlush;
    logic                  IDEXBubble;
    logic                  Busy;
    logic [STAT_W-1:0]     StallCount;

    modport master (
        output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
               BranchTaken, MulStart,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Busy, StallCount
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
               BranchTaken, MulStart,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Busy, StallCount
    );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Front-end stall/flush control: load-use interlock, multiply hold-off,
// taken-branch flush and a saturating count of stalled cycles.
module hazard_stall_unit #(
    parameter int MUL_LATENCY = 4,
    parameter int REG_ADDR_W  = hazard_stall_unit_pkg::REG_ADDR_W,
    parameter int STAT_W      = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    hazard_stall_unit_if.slave  bus
);
    import hazard_stall_unit_pkg::*;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] mul_cnt, mul_cnt_nxt;
    logic             hz;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, busy;

    logic [REG_ADDR_W-1:0] ex_rt, id_rs, id_rt;
    assign ex_rt = bus.ID_EX_Rt;
    assign id_rs = bus.IF_ID_Rs;
    assign id_rt = bus.IF_ID_Rt;

    // A load targeting r0 never produces a value worth waiting for.
    assign hz = bus.ID_EX_MemRead && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (bus.IF_ID_UsesRt && (ex_rt == id_rt)));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        busy        = 1'b0;

        case (state)
            RUN: begin
                if (hz) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.BranchTaken) begin
                    ifid_flush = 1'b1;
                end else if (bus.MulStart) begin
                    state_nxt   = MUL_BUSY;
                    mul_cnt_nxt = MUL_LOAD;
                end
            end
            MUL_BUSY: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                busy        = 1'b1;
                if (mul_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    mul_cnt_nxt = mul_cnt - 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase

        // Reset is asynchronous, so outputs must not wait for the state register.
        if (Reset) begin
            pc_write    = PCWRITE_RST;
            ifid_write  = IFIDWRITE_RST;
            ifid_flush  = IFIDFLUSH_RST;
            idex_bubble = IDEXBUBBLE_RST;
            busy        = BUSY_RST;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.IFIDWrite  = ifid_write;
    assign bus.IFIDFlush  = ifid_flush;
    assign bus.IDEXBubble = idex_bubble;
    assign bus.Busy       = busy;

    sat_counter #(
        .WIDTH (STAT_W)
    ) u_stall_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (~pc_write),
        .count (bus.StallCount)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (MUL_LATENCY=4, STAT_W=4).
module tb_hazard_stall_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    hazard_stall_unit_if #(.REG_ADDR_W(5), .STAT_W(4)) bus ();

    hazard_stall_unit #(
        .MUL_LATENCY (4),
        .REG_ADDR_W  (5),
        .STAT_W      (4)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.ID_EX_MemRead = 1'b0;
        bus.ID_EX_Rt      = '0;
        bus.IF_ID_Rs      = '0;
        bus.IF_ID_Rt      = '0;
        bus.IF_ID_UsesRt  = 1'b0;
        bus.BranchTaken   = 1'b0;
        bus.MulStart      = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] ex_rt, input logic [4:0] rs);
        bus.ID_EX_MemRead = 1'b1;
        bus.ID_EX_Rt      = ex_rt;
        bus.IF_ID_Rs      = rs;
    endtask

    task automatic check_ctrl(input string tag, input logic pcw, input logic ifw,
                              input logic fl, input logic bub, input logic bsy);
        check_val({tag, ".PCWrite"},    32'(bus.PCWrite),    32'(pcw));
        check_val({tag, ".IFIDWrite"},  32'(bus.IFIDWrite),  32'(ifw));
        check_val({tag, ".IFIDFlush"},  32'(bus.IFIDFlush),  32'(fl));
        check_val({tag, ".IDEXBubble"}, 32'(bus.IDEXBubble), 32'(bub));
        check_val({tag, ".Busy"},       32'(bus.Busy),       32'(bsy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_idle();
        tick();
        // Hazard inputs during reset must not disturb the reset outputs.
        set_load_use(5'd8, 5'd8);
        #1;
        check_ctrl("rst_hold", 1, 1, 0, 0, 0);
        check_val("rst_hold.cnt", 32'(bus.StallCount), 0);
        tick();
        set_idle();
        rst = 1'b0;
        #1;
        check_ctrl("post_rst", 1, 1, 0, 0, 0);
        check_val("post_rst.cnt", 32'(bus.StallCount), 0);

        // Load-use on Rs.
        tick();
        set_load_use(5'd8, 5'd8);
        #1;
        check_ctrl("lu_rs", 0, 0, 0, 1, 0);
        tick();
        set_idle();
        #1;
        check_val("lu_rs.cnt", 32'(bus.StallCount), 1);
        check_ctrl("lu_rs.after", 1, 1, 0, 0, 0);

        // Load into r0 never stalls.
        set_load_use(5'd0, 5'd0);
        #1;
        check_ctrl("lu_r0", 1, 1, 0, 0, 0);
        tick();
        set_idle();
        #1;
        check_val("lu_r0.cnt", 32'(bus.StallCount), 1);

        // Rt match only counts when the instruction reads Rt.
        set_load_use(5'd5, 5'd3);
        bus.IF_ID_Rt = 5'd5;
        #1;
        check_val("lu_rt_unused.PCWrite", 32'(bus.PCWrite), 1);
        bus.IF_ID_UsesRt = 1'b1;
        #1;
        check_ctrl("lu_rt_used", 0, 0, 0, 1, 0);
        tick();
        set_idle();
        #1;
        check_val("lu_rt.cnt", 32'(bus.StallCount), 2);

        // Hazard outranks a taken branch.
        set_load_use(5'd8, 5'd8);
        bus.BranchTaken = 1'b1;
        #1;
        check_ctrl("hz_br", 0, 0, 0, 1, 0);
        tick();
        set_idle();
        #1;
        check_val("hz_br.cnt", 32'(bus.StallCount), 3);

        // Branch outranks multiply issue.
        bus.BranchTaken = 1'b1;
        bus.MulStart    = 1'b1;
        #1;
        check_ctrl("br_mul", 1, 1, 1, 0, 0);
        tick();
        set_idle();
        #1;
        check_ctrl("br_mul.after", 1, 1, 0, 0, 0);
        check_val("br_mul.cnt", 32'(bus.StallCount), 3);

        // Multiply: issue cycle unstalled, then 4 busy cycles; branch ignored.
        bus.MulStart = 1'b1;
        #1;
        check_ctrl("mul_issue", 1, 1, 0, 0, 0);
        tick();
        set_idle();
        bus.BranchTaken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_ctrl($sformatf("mul_busy%0d", i), 0, 0, 0, 1, 1);
            tick();
        end
        bus.BranchTaken = 1'b0;
        // Back-to-back multiply on the first RUN cycle.
        bus.MulStart = 1'b1;
        #1;
        check_ctrl("mul2_issue", 1, 1, 0, 0, 0);
        check_val("mul.cnt", 32'(bus.StallCount), 7);
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("mul2_busy%0d", i), 32'(bus.Busy), 1);
            tick();
        end
        #1;
        check_ctrl("mul2_done", 1, 1, 0, 0, 0);
        check_val("mul2.cnt", 32'(bus.StallCount), 11);

        // Reset in the 2nd busy cycle takes effect without a clock.
        bus.MulStart = 1'b1;
        tick();
        set_idle();
        tick();
        #1;
        check_val("mul3_busy2", 32'(bus.Busy), 1);
        rst = 1'b1;
        #1;
        check_ctrl("mid_rst", 1, 1, 0, 0, 0);
        check_val("mid_rst.cnt", 32'(bus.StallCount), 0);
        tick();
        rst = 1'b0;
        bus.MulStart = 1'b1;
        #1;
        check_ctrl("mul4_issue", 1, 1, 0, 0, 0);
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("mul4_busy%0d", i), 32'(bus.Busy), 1);
            tick();
        end
        #1;
        check_val("mul4_done.Busy", 32'(bus.Busy), 0);
        check_val("mul4.cnt", 32'(bus.StallCount), 4);

        // Saturation: 20 more stall cycles on a 4-bit counter.
        set_load_use(5'd9, 5'd9);
        for (int i = 0; i < 20; i++) tick();
        set_idle();
        #1;
        check_val("sat.cnt", 32'(bus.StallCount), 15);
        set_load_use(5'd9, 5'd9);
        tick();
        set_idle();
        #1;
        check_val("sat_hold.cnt", 32'(bus.StallCount), 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline control block that produces the PCWrite enable consumed by the PC register, plus the IF/ID write enable, IF/ID flush and ID/EX bubble controls.
- Detects load-use hazards, holds the front end for multi-cycle multiply issue, and flushes on taken branches.
- Keeps a saturating stall-cycle counter for performance measurement.
- Sits beside the ID stage; its outputs feed the PC, the IF/ID register and the ID/EX control mux.

Parameters:
- MUL_LATENCY, 4: stall cycles inserted after a multiply issues; legal range is 1 to 255.
- REG_ADDR_W, 5: register-specifier width.
- STAT_W, 16: width of the stall-cycle counter.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ID_EX_MemRead  input  1  the instruction in EX is a load.
- ID_EX_Rt  input  REG_ADDR_W  destination register of the load in EX.
- IF_ID_Rs  input  REG_ADDR_W  first source register of the instruction in ID.
- IF_ID_Rt  input  REG_ADDR_W  second source register of the instruction in ID.
- IF_ID_UsesRt  input  1  the instruction in ID reads Rt as a source.
- BranchTaken  input  1  the branch resolved in ID is taken.
- MulStart  input  1  the instruction in ID is a multi-cycle multiply issuing this cycle.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register load enable.
- IFIDFlush  output  1  zero the IF/ID register on the next edge.
- IDEXBubble  output  1  force the ID/EX control fields to zero.
- Busy  output  1  multiply stall in progress.
- StallCount  output  STAT_W  number of cycles in which PCWrite was 0.

Behaviour:
- Clocking and reset:
  - Reset is asynchronous, active-high; clock is Clk.
  - While Reset is high: state = RUN, the multiply counter = 0, StallCount = 0.
  - Output values during reset: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, Busy=0.
- Output timing:
  - State, the multiply counter and StallCount are registered.
  - Control outputs are combinational from the current state and current inputs, so a stall takes effect in the same cycle the hazard is seen (zero latency).
- Load-use hazard (hz), defined as:
  - ID_EX_MemRead=1, and
  - ID_EX_Rt != 0, and
  - ID_EX_Rt == IF_ID_Rs, or (IF_ID_UsesRt=1 and ID_EX_Rt == IF_ID_Rt).
- State RUN, evaluated in this priority order:
  1. hz: PCWrite=0, IFIDWrite=0, IDEXBubble=1. Branch and MulStart are ignored this cycle; the stalled instruction re-presents them next cycle. State stays RUN.
  2. BranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1. MulStart is ignored. State stays RUN.
  3. MulStart: outputs are normal this cycle, so the multiply advances to EX. Next state = MUL_BUSY; the counter is loaded with MUL_LATENCY-1.
  4. Otherwise: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- State MUL_BUSY:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1, Busy=1, IFIDFlush=0.
  - All request inputs are ignored.
  - If the counter is 0, next state = RUN; otherwise the counter decrements.
  - The front end is frozen for exactly MUL_LATENCY cycles. With MUL_LATENCY=1 there is a single MUL_BUSY cycle.
- StallCount:
  - Increments on every edge where PCWrite=0.
  - Saturates at all-ones and does not wrap.
- Reset asserted mid-MUL_BUSY: immediate return to RUN with the counter cleared; the outputs show the reset values at once, without waiting for Clk.
- A back-to-back MulStart on the first RUN cycle after MUL_BUSY is accepted and restarts a full MUL_LATENCY stall.
- A load-use hazard against register 0 never stalls.

Decomposition:
- Shared package:
  - State encoding constants: RUN=1'b0, MUL_BUSY=1'b1.
  - REG_ADDR_W.
  - The reset-value constants for the control outputs.
- One natural sub-module: sat_counter, a parameterised width, increment-enable, saturating counter with asynchronous reset. It implements StallCount and is reusable by other performance counters.

Test Plan:
- Reset mid-run, then release: PCWrite=1, IFIDWrite=1, IDEXBubble=0, Busy=0, StallCount=0 before the first edge.
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for one cycle -> that cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1, and StallCount goes 0->1. Repeating with ID_EX_Rt=0 -> no stall.
- Multiply with MUL_LATENCY=4: MulStart pulse -> the issue cycle is unstalled, then exactly 4 cycles with PCWrite=0 and Busy=1, then RUN. StallCount=4. BranchTaken asserted during the busy window is ignored.
- Priority: hz and BranchTaken together -> stall with IFIDFlush=0. BranchTaken and MulStart together -> IFIDFlush=1 and no MUL_BUSY entry.
- Reset asserted in the 2nd MUL_BUSY cycle -> Busy=0 and PCWrite=1 immediately. After release, a MulStart gives a full 4-cycle stall.
- Saturation with STAT_W=4: force 20 stall cycles -> StallCount holds at 15.
